// File: rtl/multi_ch_timer_if.sv
// Avalon-MM slave bus bundle for multi_ch_timer.
// Signals:
//   address[4:0]    {channel[1:0], register[2:0]}
//   chipselect      slave select (qualifies writes only)
//   write_n         active-low write strobe
//   writedata[15:0] write data
//   readdata[15:0]  registered read data, driven by the slave
interface multi_ch_timer_if;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/multi_ch_timer.sv
// Multi-channel down-counting interval timer with Avalon-MM register access.
// Each channel counts down once per cycle while running, reloads from its
// period at zero, flags a sticky timeout and optionally raises an interrupt.
// Optional PWM compare logic is built only when MULTI_CH_TIMER_PWM_EN is defined.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       multi_ch_timer_if.slave (address/chipselect/write_n/writedata/readdata)
//   irq_vec   per-channel interrupt (to AND ito, combinational from registers)
//   irq       OR of irq_vec
//   pwm_out   per-channel registered PWM output (tied 0 without the macro)
// Per-channel registers: 0 status {run,to}, 1 control {stop,start,cont,ito},
//   2/3 period lo/hi, 4/5 snapshot lo/hi, 6/7 compare lo/hi.
module multi_ch_timer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned COUNT_W      = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  multi_ch_timer_if.slave   bus,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int unsigned        HI_W      = COUNT_W - 16;
  localparam logic [COUNT_W-1:0] RESET_VAL = COUNT_W'(RESET_PERIOD);

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_PER_L  = 3'd2;
  localparam logic [2:0] REG_PER_H  = 3'd3;
  localparam logic [2:0] REG_SNAP_L = 3'd4;
  localparam logic [2:0] REG_SNAP_H = 3'd5;
  localparam logic [2:0] REG_CMP_L  = 3'd6;
  localparam logic [2:0] REG_CMP_H  = 3'd7;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  logic [COUNT_W-1:0] cnt_q    [NUM_CH];
  logic [COUNT_W-1:0] cnt_d    [NUM_CH];
  logic [COUNT_W-1:0] period_q [NUM_CH];
  logic [COUNT_W-1:0] period_d [NUM_CH];
  logic [COUNT_W-1:0] snap_q   [NUM_CH];
  logic [COUNT_W-1:0] snap_d   [NUM_CH];
  logic [3:0]         ctrl_q   [NUM_CH];
  logic [3:0]         ctrl_d   [NUM_CH];
  logic [NUM_CH-1:0]  run_q, run_d;
  logic [NUM_CH-1:0]  to_q, to_d;
  logic [NUM_CH-1:0]  zero_q, zero_d;
  logic [NUM_CH-1:0]  reload_q, reload_d;
`ifdef MULTI_CH_TIMER_PWM_EN
  logic [COUNT_W-1:0] cmp_q    [NUM_CH];
  logic [COUNT_W-1:0] cmp_d    [NUM_CH];
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
`endif

  logic        wr_en_c;
  logic [1:0]  ch_sel;
  logic [2:0]  reg_sel;
  logic [15:0] rdata_c;

  assign wr_en_c = bus.chipselect & ~bus.write_n;
  assign ch_sel  = bus.address[4:3];
  assign reg_sel = bus.address[2:0];

  // Selects the low or high 16-bit half of a counter-width value, zero-filled.
  function automatic logic [15:0] word_sel(input logic [COUNT_W-1:0] v, input logic hi);
    logic [31:0] w;
    w = 32'(v);
    return hi ? w[31:16] : w[15:0];
  endfunction

  // Per-channel next-state: counting, timeout, register writes, force-reload.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      cnt_d[n]    = cnt_q[n];
      period_d[n] = period_q[n];
      snap_d[n]   = snap_q[n];
      ctrl_d[n]   = ctrl_q[n];
      run_d[n]    = run_q[n];
      to_d[n]     = to_q[n];
      reload_d[n] = 1'b0;
      zero_d[n]   = (cnt_q[n] == '0);
`ifdef MULTI_CH_TIMER_PWM_EN
      cmp_d[n]    = cmp_q[n];
      pwm_d[n]    = run_q[n] && (cnt_q[n] < cmp_q[n]);
`endif

      // Timeout fires only on the cycle the counter arrives at zero.
      if ((cnt_q[n] == '0) && !zero_q[n]) begin
        to_d[n] = 1'b1;
      end

      if (run_q[n]) begin
        if (cnt_q[n] == '0) begin
          cnt_d[n] = period_q[n];
          if (!ctrl_q[n][CTRL_CONT]) begin
            run_d[n] = 1'b0;
          end
        end else begin
          cnt_d[n] = cnt_q[n] - COUNT_W'(1);
        end
      end

      if (wr_en_c && (ch_sel == 2'(n))) begin
        case (reg_sel)
          REG_STATUS: to_d[n] = 1'b0;
          REG_CTRL: begin
            ctrl_d[n] = bus.writedata[3:0];
            // start has priority over stop in the same write
            if (bus.writedata[CTRL_START]) begin
              run_d[n] = 1'b1;
            end else if (bus.writedata[CTRL_STOP]) begin
              run_d[n] = 1'b0;
            end
          end
          REG_PER_L: begin
            period_d[n][15:0] = bus.writedata;
            reload_d[n]       = 1'b1;
          end
          REG_PER_H: begin
            period_d[n][COUNT_W-1:16] = bus.writedata[HI_W-1:0];
            reload_d[n]               = 1'b1;
          end
          REG_SNAP_L, REG_SNAP_H: snap_d[n] = cnt_q[n];
`ifdef MULTI_CH_TIMER_PWM_EN
          REG_CMP_L: cmp_d[n][15:0] = bus.writedata;
          REG_CMP_H: cmp_d[n][COUNT_W-1:16] = bus.writedata[HI_W-1:0];
`endif
          default: ;
        endcase
      end

      // Cycle after a period write: load the new period and halt the channel.
      if (reload_q[n]) begin
        cnt_d[n] = period_q[n];
        run_d[n] = 1'b0;
      end
    end
  end

  // Read mux; unmatched channel indices fall through to zero.
  always_comb begin
    rdata_c = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel == 2'(n)) begin
        case (reg_sel)
          REG_STATUS: rdata_c = {14'b0, run_q[n], to_q[n]};
          REG_CTRL:   rdata_c = {12'b0, ctrl_q[n]};
          REG_PER_L:  rdata_c = word_sel(period_q[n], 1'b0);
          REG_PER_H:  rdata_c = word_sel(period_q[n], 1'b1);
          REG_SNAP_L: rdata_c = word_sel(snap_q[n], 1'b0);
          REG_SNAP_H: rdata_c = word_sel(snap_q[n], 1'b1);
`ifdef MULTI_CH_TIMER_PWM_EN
          REG_CMP_L:  rdata_c = word_sel(cmp_q[n], 1'b0);
          REG_CMP_H:  rdata_c = word_sel(cmp_q[n], 1'b1);
`endif
          default:    rdata_c = '0;
        endcase
      end
    end
  end

  // State and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n]    <= RESET_VAL;
        period_q[n] <= RESET_VAL;
        snap_q[n]   <= '0;
        ctrl_q[n]   <= '0;
`ifdef MULTI_CH_TIMER_PWM_EN
        cmp_q[n]    <= '0;
`endif
      end
      run_q        <= '0;
      to_q         <= '0;
      zero_q       <= {NUM_CH{RESET_VAL == '0}};
      reload_q     <= '0;
`ifdef MULTI_CH_TIMER_PWM_EN
      pwm_q        <= '0;
`endif
      bus.readdata <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n]    <= cnt_d[n];
        period_q[n] <= period_d[n];
        snap_q[n]   <= snap_d[n];
        ctrl_q[n]   <= ctrl_d[n];
`ifdef MULTI_CH_TIMER_PWM_EN
        cmp_q[n]    <= cmp_d[n];
`endif
      end
      run_q        <= run_d;
      to_q         <= to_d;
      zero_q       <= zero_d;
      reload_q     <= reload_d;
`ifdef MULTI_CH_TIMER_PWM_EN
      pwm_q        <= pwm_d;
`endif
      bus.readdata <= rdata_c;
    end
  end

  // Interrupts follow the sticky timeout gated by the per-channel enable.
  always_comb begin
    irq_vec = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      irq_vec[n] = to_q[n] & ctrl_q[n][CTRL_ITO];
    end
  end

  assign irq = |irq_vec;

`ifdef MULTI_CH_TIMER_PWM_EN
  assign pwm_out = pwm_q;
`else
  assign pwm_out = '0;
`endif

endmodule

// File: doc/multi_ch_timer.md
MULTI_CH_TIMER -- requirements
Module: multi_ch_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (legal 1..4).
REQ-002 SHALL have parameter COUNT_W, default 32, counter width in bits (legal 17..32).
REQ-003 SHALL have parameter RESET_PERIOD, default 49999, period and counter value loaded at reset.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  5  [4:3] channel select, [2:0] register select.
REQ-007 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-008 SHALL have port write_n  input  1  write strobe, active-low, qualified by chipselect.
REQ-009 SHALL have port writedata  input  16  write data.
REQ-010 SHALL have port readdata  output  16  registered read data.
REQ-011 SHALL have port irq_vec  output  NUM_CH  per-channel interrupt.
REQ-012 SHALL have port irq  output  1  OR of irq_vec.
REQ-013 SHALL have port pwm_out  output  NUM_CH  per-channel PWM output.

Function
REQ-014 SHALL decode registers per channel: 0 status {run,to}; 1 control {stop,start,cont,ito}; 2 period_l; 3 period_h; 4 snap_l; 5 snap_h; 6 cmp_l; 7 cmp_h.
REQ-015 SHALL update readdata every cycle from current address (1-cycle read latency, chipselect ignored); channel index >= NUM_CH reads 0; register bits above COUNT_W read 0.
REQ-016 SHALL decrement a running channel counter by 1 per cycle; at 0 load {period_h,period_l}[COUNT_W-1:0] instead of decrementing.
REQ-017 SHALL raise timeout event on the first cycle counter==0 (zero now, nonzero previous cycle); set sticky "to" bit.
REQ-018 SHALL clear "to" on any write to status; simultaneous clear and timeout -> clear wins.
REQ-019 SHALL drive irq_vec[n] = to[n] AND ito[n], combinationally from registers.
REQ-020 SHALL set run on control write with writedata[2]=1; clear run on writedata[3]=1, on force-reload, or at counter==0 with cont=0; start and stop in same write -> start wins.
REQ-021 SHALL, on write to period_l or period_h, assert force-reload the next cycle: counter loads new period and run clears in that cycle.
REQ-022 SHALL, on write to snap_l or snap_h, capture the channel counter into its snapshot register at that clock edge.
REQ-023 SHALL keep channels fully independent; a write affects only the addressed channel.
REQ-024 SHALL store control bits [3:0] as written; stop/start read back as last written.

Reset
REQ-025 SHALL on reset_n low set: counters and periods = RESET_PERIOD; compare, snapshot, control, run, to = 0; readdata = 0; irq, irq_vec, pwm_out = 0.
REQ-026 SHALL, when reset asserts mid-count, abort immediately; after release no channel runs until started.

Configuration
REQ-027 SHALL compile PWM compare logic only when macro MULTI_CH_TIMER_PWM_EN is defined: pwm_out[n] = run[n] AND (counter[n] < {cmp_h,cmp_l}[COUNT_W-1:0]), registered (1 cycle after compare).
REQ-028 SHALL, without MULTI_CH_TIMER_PWM_EN, omit compare registers: cmp_l/cmp_h writes ignored, read 0; pwm_out tied 0.

Verification
REQ-029 SHALL cover: reset, read ch0 status -> readdata 0x0000 after 1 cycle; ch0 period_l -> 49999 (0xC34F).
REQ-030 SHALL cover: ch1 period=4, control=0x7 (start,cont,ito) -> irq_vec[1] rises 5 cycles after start, repeats every 5 cycles; status write clears it.
REQ-031 SHALL cover: ch2 period=3, control=0x5 (one-shot) -> single timeout, run=0 afterwards, counter holds reload value 3.
REQ-032 SHALL cover: ch0 running, write period_h=0x0001 -> next cycle run=0, counter=0x0001C34F; status reads 0x0000.
REQ-033 SHALL cover: status-clear write on exact timeout cycle -> to stays 0; control write 0xC -> run=1.
REQ-034 SHALL cover (PWM_EN): ch3 period=9, cmp=3, continuous -> pwm_out[3] high 3 of every 10 cycles; without macro pwm_out=0, cmp reads 0.
